// File: rtl/reg_writeback.sv
// Writeback stage: commits ALU results after one cycle. Loads wait for a memory response,
// are lane-extracted and sign/zero-extended, and time out with a sticky error if no response arrives.
module reg_writeback #(
    parameter int DATA_W  = 32,
    parameter int TMO_MAX = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        in_rd,
    input  logic              in_regwrite,
    input  logic              in_memtoreg,
    input  logic [DATA_W-1:0] in_alu_result,
    input  logic [1:0]        in_ld_size,
    input  logic              in_ld_unsigned,
    input  logic              mem_rsp_valid,
    input  logic [DATA_W-1:0] mem_rsp_data,
    output logic              RegWrite,
    output logic [4:0]        WriteRegister,
    output logic [DATA_W-1:0] WriteData,
    output logic              busy,
    output logic              tmo_err,
    output logic              rsp_err
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_MEM = 2'd1,
        COMMIT   = 2'd2
    } state_t;

    // The wait counter is 8 bits wide, so the limit is taken modulo 256.
    localparam logic [7:0] TMO_LIM = 8'(TMO_MAX);

    state_t             state_q, state_d;
    logic [7:0]         cnt_q, cnt_d;
    logic [4:0]         ld_rd_q, ld_rd_d;
    logic [1:0]         ld_addr_q, ld_addr_d;
    logic [1:0]         ld_size_q, ld_size_d;
    logic               ld_uns_q, ld_uns_d;
    logic               regwrite_q, regwrite_d;
    logic [4:0]         wreg_q, wreg_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic               tmo_q, tmo_d;
    logic               rsperr_q, rsperr_d;
    logic               xfer_s;

    function automatic logic [DATA_W-1:0] extract_load(
        input logic [DATA_W-1:0] word,
        input logic [1:0]        addr,
        input logic [1:0]        size,
        input logic              uns
    );
        logic [7:0]        b;
        logic [15:0]       h;
        logic [DATA_W-1:0] r;
        b = word[{addr, 3'b000} +: 8];
        h = word[{addr[1], 4'b0000} +: 16];
        case (size)
            2'b00:   r = uns ? {{(DATA_W-8){1'b0}}, b}  : {{(DATA_W-8){b[7]}}, b};
            2'b01:   r = uns ? {{(DATA_W-16){1'b0}}, h} : {{(DATA_W-16){h[15]}}, h};
            default: r = word;
        endcase
        return r;
    endfunction

    assign in_ready      = (state_q != WAIT_MEM);
    assign busy          = (state_q != IDLE);
    assign xfer_s        = in_valid & in_ready;
    assign RegWrite      = regwrite_q;
    assign WriteRegister = wreg_q;
    assign WriteData     = wdata_q;
    assign tmo_err       = tmo_q;
    assign rsp_err       = rsperr_q;

    // Next-state, capture and write-port logic.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ld_rd_d    = ld_rd_q;
        ld_addr_d  = ld_addr_q;
        ld_size_d  = ld_size_q;
        ld_uns_d   = ld_uns_q;
        regwrite_d = 1'b0;
        wreg_d     = wreg_q;
        wdata_d    = wdata_q;
        tmo_d      = tmo_q;
        rsperr_d   = rsperr_q | (mem_rsp_valid & (state_q != WAIT_MEM));
        case (state_q)
            IDLE, COMMIT: begin
                if (!xfer_s) begin
                    state_d = IDLE;
                end else if (!in_regwrite || (in_rd == 5'd0)) begin
                    state_d = IDLE;
                end else if (!in_memtoreg) begin
                    state_d    = COMMIT;
                    regwrite_d = 1'b1;
                    wreg_d     = in_rd;
                    wdata_d    = in_alu_result;
                end else begin
                    state_d   = WAIT_MEM;
                    cnt_d     = 8'd0;
                    ld_rd_d   = in_rd;
                    ld_addr_d = in_alu_result[1:0];
                    ld_size_d = in_ld_size;
                    ld_uns_d  = in_ld_unsigned;
                end
            end
            WAIT_MEM: begin
                if (mem_rsp_valid) begin
                    state_d    = COMMIT;
                    regwrite_d = 1'b1;
                    wreg_d     = ld_rd_q;
                    wdata_d    = extract_load(mem_rsp_data, ld_addr_q, ld_size_q, ld_uns_q);
                end else if ((cnt_q + 8'd1) == TMO_LIM) begin
                    cnt_d   = cnt_q + 8'd1;
                    tmo_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset clears everything asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= 8'd0;
            ld_rd_q    <= 5'd0;
            ld_addr_q  <= 2'd0;
            ld_size_q  <= 2'd0;
            ld_uns_q   <= 1'b0;
            regwrite_q <= 1'b0;
            wreg_q     <= 5'd0;
            wdata_q    <= '0;
            tmo_q      <= 1'b0;
            rsperr_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ld_rd_q    <= ld_rd_d;
            ld_addr_q  <= ld_addr_d;
            ld_size_q  <= ld_size_d;
            ld_uns_q   <= ld_uns_d;
            regwrite_q <= regwrite_d;
            wreg_q     <= wreg_d;
            wdata_q    <= wdata_d;
            tmo_q      <= tmo_d;
            rsperr_q   <= rsperr_d;
        end
    end

endmodule

// File: tb/tb_reg_writeback.sv
// Self-checking bench for reg_writeback: directed cases with literal expectations plus
// randomized traffic compared every cycle against a transaction-level reference model.
module tb_reg_writeback;

    localparam int TMO = 12;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid, in_ready, in_regwrite, in_memtoreg, in_ld_unsigned;
    logic [4:0]  in_rd;
    logic [31:0] in_alu_result;
    logic [1:0]  in_ld_size;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic        RegWrite, busy, tmo_err, rsp_err;
    logic [4:0]  WriteRegister;
    logic [31:0] WriteData;

    int errors = 0;
    int checks = 0;

    // Reference model: an outstanding-load record plus the expected write port and flags.
    logic        m_pend, m_commit;
    int          m_wait;
    logic [4:0]  m_rd;
    logic [1:0]  m_addr, m_size;
    logic        m_uns;
    logic        exp_we, exp_tmo, exp_rerr;
    logic [4:0]  exp_wr;
    logic [31:0] exp_wd;

    always #5 clk = ~clk;

    reg_writeback #(.DATA_W(32), .TMO_MAX(TMO)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_rd(in_rd),
        .in_regwrite(in_regwrite), .in_memtoreg(in_memtoreg),
        .in_alu_result(in_alu_result), .in_ld_size(in_ld_size),
        .in_ld_unsigned(in_ld_unsigned),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
        .RegWrite(RegWrite), .WriteRegister(WriteRegister), .WriteData(WriteData),
        .busy(busy), .tmo_err(tmo_err), .rsp_err(rsp_err)
    );

    function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [1:0] a,
                                             input logic [1:0] sz, input logic uns);
        logic [31:0] v;
        if (sz == 2'b00) begin
            v = (w >> (8 * a)) & 32'h0000_00FF;
            if (!uns && v >= 32'd128) v = v - 32'd256;
        end else if (sz == 2'b01) begin
            v = (w >> ((a >= 2'd2) ? 16 : 0)) & 32'h0000_FFFF;
            if (!uns && v >= 32'd32768) v = v - 32'd65536;
        end else begin
            v = w;
        end
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pend = 1'b0; m_commit = 1'b0; m_wait = 0;
        m_rd = 5'd0; m_addr = 2'd0; m_size = 2'd0; m_uns = 1'b0;
        exp_we = 1'b0; exp_wr = 5'd0; exp_wd = 32'd0; exp_tmo = 1'b0; exp_rerr = 1'b0;
    endtask

    // Advance the model by one rising edge using the inputs currently applied.
    task automatic model_step();
        exp_we = 1'b0;
        m_commit = 1'b0;
        if (mem_rsp_valid && !m_pend) exp_rerr = 1'b1;
        if (m_pend) begin
            if (mem_rsp_valid) begin
                exp_we = 1'b1; exp_wr = m_rd;
                exp_wd = ref_load(mem_rsp_data, m_addr, m_size, m_uns);
                m_pend = 1'b0; m_commit = 1'b1;
            end else begin
                m_wait++;
                if (m_wait == TMO) begin
                    exp_tmo = 1'b1; m_pend = 1'b0;
                end
            end
        end else if (in_valid && in_regwrite && in_rd != 5'd0) begin
            if (!in_memtoreg) begin
                exp_we = 1'b1; exp_wr = in_rd; exp_wd = in_alu_result; m_commit = 1'b1;
            end else begin
                m_pend = 1'b1; m_wait = 0; m_rd = in_rd;
                m_addr = in_alu_result[1:0]; m_size = in_ld_size; m_uns = in_ld_unsigned;
            end
        end
    endtask

    task automatic compare_all();
        check("RegWrite", 32'(RegWrite), 32'(exp_we));
        check("WriteRegister", 32'(WriteRegister), 32'(exp_wr));
        check("WriteData", WriteData, exp_wd);
        check("tmo_err", 32'(tmo_err), 32'(exp_tmo));
        check("rsp_err", 32'(rsp_err), 32'(exp_rerr));
        check("in_ready", 32'(in_ready), 32'(!m_pend));
        check("busy", 32'(busy), 32'(m_pend || m_commit));
    endtask

    task automatic tick();
        model_step();
        @(negedge clk);
        #1;
        if (!rst) compare_all();
    endtask

    task automatic clr_in();
        in_valid = 1'b0; in_rd = 5'd0; in_regwrite = 1'b0; in_memtoreg = 1'b0;
        in_alu_result = 32'd0; in_ld_size = 2'd0; in_ld_unsigned = 1'b0;
        mem_rsp_valid = 1'b0; mem_rsp_data = 32'd0;
    endtask

    task automatic set_in(input logic [4:0] rd, input logic rw, input logic m2r,
                          input logic [31:0] alu, input logic [1:0] sz, input logic uns);
        in_valid = 1'b1; in_rd = rd; in_regwrite = rw; in_memtoreg = m2r;
        in_alu_result = alu; in_ld_size = sz; in_ld_unsigned = uns;
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_we"}, 32'(RegWrite), 32'd0);
        check({tag, "_wr"}, 32'(WriteRegister), 32'd0);
        check({tag, "_wd"}, WriteData, 32'd0);
        check({tag, "_tmo"}, 32'(tmo_err), 32'd0);
        check({tag, "_rerr"}, 32'(rsp_err), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    // Pulse rst in the middle of a cycle, check outputs while it is held, release it.
    task automatic do_reset();
        model_step();
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_zero_outputs("rst_hold");
        clr_in();
        @(negedge clk);
        #1;
        rst = 1'b0;
        check("ready_after_rst", 32'(in_ready), 32'd1);
    endtask

    task automatic load_case(input string tag, input logic [31:0] addr, input logic [1:0] sz,
                             input logic uns, input logic [31:0] data, input int waits,
                             input logic [31:0] expect_wd);
        set_in(5'd7, 1'b1, 1'b1, addr, sz, uns);
        tick();
        clr_in();
        for (int i = 0; i < waits; i++) begin
            check({tag, "_ready_wait"}, 32'(in_ready), 32'd0);
            tick();
        end
        check({tag, "_ready_wait"}, 32'(in_ready), 32'd0);
        mem_rsp_valid = 1'b1; mem_rsp_data = data;
        tick();
        clr_in();
        check({tag, "_we"}, 32'(RegWrite), 32'd1);
        check({tag, "_wr"}, 32'(WriteRegister), 32'd7);
        check({tag, "_wd"}, WriteData, expect_wd);
        check({tag, "_model"}, exp_wd, expect_wd);
        tick();
    endtask

    initial begin
        int writes;
        clr_in();
        model_reset();
        #1;
        check_zero_outputs("por");
        check("por_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        #1;
        rst = 1'b0;
        check("ready_after_por", 32'(in_ready), 32'd1);

        // ALU commit latency and single-cycle pulse
        set_in(5'd5, 1'b1, 1'b0, 32'h1234_5678, 2'd0, 1'b0);
        tick();
        clr_in();
        check("alu_we", 32'(RegWrite), 32'd1);
        check("alu_wr", 32'(WriteRegister), 32'd5);
        check("alu_wd", WriteData, 32'h1234_5678);
        tick();
        check("alu_we_drop", 32'(RegWrite), 32'd0);
        check("alu_wd_hold", WriteData, 32'h1234_5678);

        // Loads: byte signed/unsigned, half signed upper lane, word
        load_case("ldb_s", 32'h0000_1002, 2'b00, 1'b0, 32'h0080_0000, 0, 32'hFFFF_FF80);
        load_case("ldb_u", 32'h0000_1002, 2'b00, 1'b1, 32'h0080_0000, 1, 32'h0000_0080);
        load_case("ldh_s", 32'h0000_2003, 2'b01, 1'b0, 32'h8001_0000, 3, 32'hFFFF_8001);
        load_case("ldw", 32'h0000_2001, 2'b10, 1'b0, 32'hCAFE_F00D, 2, 32'hCAFE_F00D);

        // Back-to-back ALU results to rd 3,4,0,6
        writes = 0;
        for (int i = 0; i < 4; i++) begin
            logic [4:0] rd_seq [4];
            rd_seq[0] = 5'd3; rd_seq[1] = 5'd4; rd_seq[2] = 5'd0; rd_seq[3] = 5'd6;
            set_in(rd_seq[i], 1'b1, 1'b0, 32'd100 + 32'(i), 2'd0, 1'b0);
            tick();
            if (RegWrite) writes++;
            if (i == 1) check("b2b_wr4", 32'(WriteRegister), 32'd4);
            if (i == 2) check("b2b_rd0_we", 32'(RegWrite), 32'd0);
            if (i == 3) check("b2b_wr6", 32'(WriteRegister), 32'd6);
        end
        clr_in();
        check("b2b_writes", 32'(writes), 32'd3);
        tick();

        // Load timeout, then a stray response in IDLE
        set_in(5'd9, 1'b1, 1'b1, 32'h0000_0000, 2'b10, 1'b0);
        tick();
        clr_in();
        for (int i = 0; i < TMO - 1; i++) begin
            tick();
            check("tmo_busy", 32'(busy), 32'd1);
            check("tmo_early", 32'(tmo_err), 32'd0);
        end
        tick();
        check("tmo_set", 32'(tmo_err), 32'd1);
        check("tmo_nowrite", 32'(RegWrite), 32'd0);
        check("tmo_idle", 32'(busy), 32'd0);
        check("tmo_model", 32'(exp_tmo), 32'd1);
        mem_rsp_valid = 1'b1; mem_rsp_data = 32'h1111_2222;
        tick();
        clr_in();
        check("stray_rerr", 32'(rsp_err), 32'd1);
        check("stray_nowrite", 32'(RegWrite), 32'd0);

        // Reset mid-wait, then a late response
        do_reset();
        set_in(5'd12, 1'b1, 1'b1, 32'h0000_0001, 2'b00, 1'b0);
        tick();
        clr_in();
        tick();
        do_reset();
        mem_rsp_valid = 1'b1; mem_rsp_data = 32'hFFFF_FFFF;
        tick();
        clr_in();
        check("rst_abort_nowrite", 32'(RegWrite), 32'd0);
        check("rst_abort_rerr", 32'(rsp_err), 32'd1);
        check("rst_abort_wr", 32'(WriteRegister), 32'd0);

        // Randomized traffic; odd blocks use rare responses to provoke timeouts
        for (int b = 0; b < 6; b++) begin
            do_reset();
            for (int c = 0; c < 400; c++) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_rd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                in_regwrite = ($urandom_range(0, 9) != 0);
                in_memtoreg = 1'($urandom_range(0, 1));
                in_alu_result = $urandom;
                in_ld_size = 2'($urandom_range(0, 3));
                in_ld_unsigned = 1'($urandom_range(0, 1));
                mem_rsp_valid = (b % 2 == 0) ? ($urandom_range(0, 2) == 0)
                                             : ($urandom_range(0, 29) == 0);
                mem_rsp_data = $urandom;
                tick();
            end
            clr_in();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/reg_writeback.md
REG_WRITEBACK -- requirements
Module: reg_writeback

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register data width; parameter TMO_MAX, default 255, maximum load-wait cycles.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port in_valid  input  1  MEM-stage result valid.
REQ-005 SHALL have port in_ready  output  1  block accepts a result this cycle.
REQ-006 SHALL have port in_rd  input  5  destination register index.
REQ-007 SHALL have port in_regwrite  input  1  result is to be written.
REQ-008 SHALL have port in_memtoreg  input  1  result comes from a load (memory response).
REQ-009 SHALL have port in_alu_result  input  DATA_W  ALU result or load address.
REQ-010 SHALL have port in_ld_size  input  2  load size: 00 byte, 01 half, 10/11 word.
REQ-011 SHALL have port in_ld_unsigned  input  1  zero-extend (1) or sign-extend (0) sub-word loads.
REQ-012 SHALL have port mem_rsp_valid  input  1  load data valid, one-cycle pulse.
REQ-013 SHALL have port mem_rsp_data  input  DATA_W  aligned 32-bit memory word.
REQ-014 SHALL have ports RegWrite  output  1, WriteRegister  output  5, WriteData  output  DATA_W  register-file write port.
REQ-015 SHALL have ports busy  output  1  (state != IDLE); tmo_err  output  1  sticky load timeout; rsp_err  output  1  sticky unexpected response.

Function
REQ-016 SHALL implement FSM states IDLE, WAIT_MEM, COMMIT.
REQ-017 in_ready SHALL be 1 in IDLE and COMMIT, 0 in WAIT_MEM; transfer occurs on in_valid & in_ready.
REQ-018 Transfer with in_regwrite=0 or in_rd=0 SHALL be discarded: no write, next state IDLE.
REQ-019 Transfer with in_memtoreg=0 SHALL go to COMMIT, driving WriteData=in_alu_result, WriteRegister=in_rd, RegWrite=1 on the next cycle (1-cycle latency).
REQ-020 Transfer with in_memtoreg=1 SHALL capture in_rd, in_alu_result[1:0], in_ld_size and in_ld_unsigned, then go to WAIT_MEM.
REQ-021 In WAIT_MEM, mem_rsp_valid SHALL go to COMMIT with extracted data written the following cycle.
REQ-022 Byte extraction SHALL take lane addr[1:0] (bits 8*addr+7:8*addr); half extraction SHALL take lane addr[1] (addr[0] ignored); word SHALL pass through.
REQ-023 Sub-word data SHALL be zero-extended if unsigned, else sign-extended from its MSB to DATA_W.
REQ-024 RegWrite SHALL be high for exactly one cycle per commit; WriteRegister/WriteData SHALL hold their last values otherwise.
REQ-025 In COMMIT without a transfer, next state SHALL be IDLE; with a transfer, REQ-018..020 apply (back-to-back ALU results, one per cycle).
REQ-026 8-bit wait counter SHALL clear on entering WAIT_MEM and increment each WAIT_MEM cycle without a response; on reaching TMO_MAX, tmo_err SHALL set, the load SHALL be dropped without a write, and the state SHALL go to IDLE.
REQ-027 mem_rsp_valid outside WAIT_MEM, including the cycle the load is accepted, SHALL be ignored and SHALL set rsp_err.
REQ-028 All outputs except in_ready and busy SHALL be registered.

Reset
REQ-029 rst SHALL force IDLE, RegWrite=0, WriteRegister=0, WriteData=0, tmo_err=0, rsp_err=0 and counter=0 immediately, independent of clk.
REQ-030 rst asserted in WAIT_MEM or COMMIT SHALL abort the operation with no write after release.
REQ-031 After rst deasserts, in_ready SHALL be 1 at the first rising edge.

Verification
REQ-032 ALU: in_rd=5, in_alu_result=0x1234_5678, memtoreg=0 at cycle N -> cycle N+1 RegWrite=1, WriteRegister=5, WriteData=0x1234_5678; cycle N+2 RegWrite=0.
REQ-033 Load byte signed: addr=0x...02, rsp_data=0x00_80_00_00 -> WriteData=0xFFFF_FF80; same with unsigned -> 0x0000_0080.
REQ-034 Load half signed, addr[1]=1, rsp_data=0x8001_0000 -> WriteData=0xFFFF_8001; in_ready=0 for every WAIT_MEM cycle.
REQ-035 Back-to-back ALU results to rd 3,4,0,6 on consecutive cycles -> writes to 3,4,6 only; no gap between 3 and 4.
REQ-036 Load with no response for TMO_MAX cycles -> tmo_err=1, no RegWrite pulse, return to IDLE; stray mem_rsp_valid in IDLE -> rsp_err=1, no write.
REQ-037 rst pulse mid-WAIT_MEM, then mem_rsp_valid -> no write, rsp_err=1, all outputs zero during rst.
